// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: instruction fields from IF/ID in, pipeline
// interlock controls and scoreboard status out.
interface hazard_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int LAT_W  = 3,
    parameter int CNT_W  = 16
);
    logic                    id_valid;
    logic [ADDR_W-1:0]       id_rs;
    logic [ADDR_W-1:0]       id_rt;
    logic                    id_uses_rs;
    logic                    id_uses_rt;
    logic                    id_writes;
    logic [ADDR_W-1:0]       id_dest;
    logic [LAT_W-1:0]        id_lat;
    logic                    flush;
    logic                    pc_write;
    logic                    if_id_write;
    logic                    control_nop;
    logic [(2**ADDR_W)-1:0]  busy_vec;
    logic [CNT_W-1:0]        stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_writes, id_dest, id_lat, flush,
        input  pc_write, if_id_write, control_nop, busy_vec, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_writes, id_dest, id_lat, flush,
        output pc_write, if_id_write, control_nop, busy_vec, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard interlocking the ID instruction on RAW and
// WAW hazards for results of any latency, with flush priority and stall counter.
module hazard_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int LAT_W  = 3,
    parameter int CNT_W  = 16
) (
    input logic                clk,
    input logic                rst_n,
    hazard_scoreboard_if.slave hz
);
    localparam int NREG = 2 ** ADDR_W;

    logic [LAT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  busy;
    logic [CNT_W-1:0] stall_count_q;
    logic             rs_hazard;
    logic             rt_hazard;
    logic             raw;
    logic             waw;
    logic             stall;
    logic             issue;

    // Register 0 is excluded explicitly so a stray write to it can never interlock.
    always_comb begin
        rs_hazard = hz.id_uses_rs && (hz.id_rs != '0) && (cnt[hz.id_rs] != '0);
        rt_hazard = hz.id_uses_rt && (hz.id_rt != '0) && (cnt[hz.id_rt] != '0);
        raw       = hz.id_valid && (rs_hazard || rt_hazard);
        waw       = hz.id_valid && hz.id_writes && (hz.id_dest != '0)
                    && (cnt[hz.id_dest] > hz.id_lat);
        stall     = (raw || waw) && !hz.flush;
        issue     = hz.id_valid && !stall && !hz.flush;
    end

    always_comb begin
        hz.pc_write    = 1'b1;
        hz.if_id_write = 1'b1;
        hz.control_nop = 1'b0;
        if (hz.flush) begin
            hz.control_nop = 1'b1;
        end else if (stall) begin
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.control_nop = 1'b1;
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    assign hz.busy_vec    = busy;
    assign hz.stall_count = stall_count_q;

    // A new issue to a register replaces its countdown rather than decrementing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0) begin
                    cnt[r] <= '0;
                end else if (issue && hz.id_writes && (hz.id_dest == ADDR_W'(r))
                             && (hz.id_lat != '0)) begin
                    cnt[r] <= hz.id_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end
endmodule
